digdug_cusio06: RTL and testbench

- Namco 06xx-style custom I/O sequencer for DigDug, placed directly upstream of the main-CPU I/O decode at $7000-$71FF.
- Holds the 06xx control register and produces the periodic NMI0 that paces main-CPU I/O transfers.
- Implements a reduced 51xx (coin/credit/switch inputs) and 53xx (DIP switch) behind the data port.
- Supplies DO/NMI to the I/O device block, which muxes DO onto the CPU bus.

---
 rtl/digdug_cusio06.sv | 231 +++++++++++++++++++++++
 tb/tb_digdug_cusio06.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/digdug_cusio06.sv
// digdug_cusio06 -- Namco 06xx-style I/O sequencer for DigDug.
//
// Holds the 06xx control register, paces main-CPU I/O with a periodic NMI,
// and answers on the data port as a reduced 51xx (coin/credit/switches) or
// 53xx (DIP switches).
//
// Build option: define DIGDUG_FREEPLAY_EN for free play. Credit-mode byte 0
// then reads 8'h99, and no coin/credit arithmetic is generated.
//
// Ports:
//   RESET      async active-high reset
//   clkdiv     block clock, all state on the rising edge
//   VBLK       vertical blank level; coin/start sampled on its rising edge
//   INP0       active-low: [0] coin1, [2] start1, [3] start2
//   INP1       active-low joystick/buttons
//   DSW0/DSW1  DIP banks
//   CS/WR/RD   chip select and single-cycle strobes
//   AD         {A8, A3:0}; AD[4]=1 control register, AD[4]=0 data port
//   DI         CPU write data
//   DO         read data, combinational from current state
//   NMI        NMI request level to the main CPU
module digdug_cusio06 #(
    parameter int NMI_UNIT   = 64,
    parameter int CREDIT_MAX = 99
) (
    input  logic       RESET,
    input  logic       clkdiv,
    input  logic       VBLK,
    input  logic [7:0] INP0,
    input  logic [7:0] INP1,
    input  logic [7:0] DSW0,
    input  logic [7:0] DSW1,
    input  logic       CS,
    input  logic       WR,
    input  logic       RD,
    input  logic [4:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       NMI
);

    // Longest period is P=7.
    localparam int CNT_W = $clog2(7 * NMI_UNIT + 1);

    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_PARAM0,
        CMD_PARAM1,
        CMD_PARAM2,
        CMD_PARAM3
    } cmd_state_t;

    logic [7:0]       ctrl;
    logic [CNT_W-1:0] nmi_cnt;
    logic [CNT_W-1:0] cnt_last;
    logic [2:0]       period;
    logic             timer_run;
    logic             terminal;
    logic             ctrl_wr;
    logic             data_acc;
    logic             cmd_wr;
    logic             param0_wr;
    logic             param1_wr;
    logic             credit_mode;
    logic [7:0]       credit_byte;
    cmd_state_t       cmd_state;

    assign ctrl_wr   = CS & WR & AD[4];
    assign data_acc  = CS & (WR | RD) & ~AD[4];
    assign cmd_wr    = CS & WR & ~AD[4] & ctrl[0] & ~ctrl[4];
    assign period    = ctrl[7:5];
    assign timer_run = (ctrl != 8'h10) && (period != 3'd0);
    assign cnt_last  = CNT_W'(int'(period) * NMI_UNIT - 1);
    assign terminal  = timer_run && (nmi_cnt == cnt_last);
    assign param0_wr = cmd_wr && (cmd_state == CMD_PARAM0);
    assign param1_wr = cmd_wr && (cmd_state == CMD_PARAM1);

    // Control register and NMI timer. Priority: control write, then the
    // terminal-count wrap, then the data-port access that acknowledges NMI.
    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            ctrl    <= 8'h10;
            nmi_cnt <= '0;
            NMI     <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl    <= DI;
            nmi_cnt <= '0;
            NMI     <= 1'b0;
        end else if (!timer_run) begin
            nmi_cnt <= '0;
            NMI     <= 1'b0;
        end else if (terminal) begin
            nmi_cnt <= '0;
            NMI     <= 1'b1;
        end else begin
            nmi_cnt <= nmi_cnt + CNT_W'(1);
            if (data_acc)
                NMI <= 1'b0;
        end
    end

    // 51xx write command sequencer; a control write abandons a parameter run.
    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            cmd_state   <= CMD_IDLE;
            credit_mode <= 1'b0;
        end else if (ctrl_wr) begin
            cmd_state <= CMD_IDLE;
        end else if (cmd_wr) begin
            case (cmd_state)
                CMD_IDLE: begin
                    case (DI)
                        8'h01:   cmd_state   <= CMD_PARAM0;
                        8'h02:   credit_mode <= 1'b1;
                        8'h03:   credit_mode <= 1'b0;
                        default: ;
                    endcase
                end
                CMD_PARAM0: cmd_state <= CMD_PARAM1;
                CMD_PARAM1: cmd_state <= CMD_PARAM2;
                CMD_PARAM2: cmd_state <= CMD_PARAM3;
                default:    cmd_state <= CMD_IDLE;
            endcase
        end
    end

`ifdef DIGDUG_FREEPLAY_EN
    assign credit_byte = 8'h99;
`else
    localparam logic [7:0] CMAX8 = 8'(CREDIT_MAX);

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'({3'd0, b[7:4]} * 7'd10 + {3'd0, b[3:0]});
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [6:0] sat_add(input logic [6:0] v, input logic [3:0] n);
        logic [7:0] s;
        s = {1'b0, v} + {4'd0, n};
        return (s > CMAX8) ? CMAX8[6:0] : s[6:0];
    endfunction

    logic [3:0] coins_per_credit;
    logic [3:0] credits_per_coin;
    logic [3:0] coin_acc;
    logic [3:0] acc_next;
    logic [4:0] acc_inc;
    logic [7:0] credits;
    logic [6:0] cred_bin;
    logic       vblk_prev;
    logic [2:0] sw_prev;    // {start2, start1, coin1} at the previous VBLK rise
    logic       vblk_rise;
    logic       coin_fall;
    logic       start1_fall;
    logic       start2_fall;

    assign vblk_rise   = VBLK & ~vblk_prev;
    assign coin_fall   = sw_prev[0] & ~INP0[0];
    assign start1_fall = sw_prev[1] & ~INP0[2];
    assign start2_fall = sw_prev[2] & ~INP0[3];

    // Coin is applied first; starts then see the updated count.
    always_comb begin
        acc_inc  = {1'b0, coin_acc} + {4'd0, coin_fall};
        acc_next = acc_inc[3:0];
        cred_bin = bcd_to_bin(credits);
        if (acc_inc >= {1'b0, coins_per_credit}) begin
            acc_next = 4'd0;
            cred_bin = sat_add(cred_bin, credits_per_coin);
        end
        if (start2_fall) begin
            if (cred_bin >= 7'd2)
                cred_bin = cred_bin - 7'd2;
        end else if (start1_fall && (cred_bin >= 7'd1)) begin
            cred_bin = cred_bin - 7'd1;
        end
    end

    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            coins_per_credit <= 4'd1;
            credits_per_coin <= 4'd1;
            coin_acc         <= 4'd0;
            credits          <= 8'h00;
            vblk_prev        <= 1'b0;
            sw_prev          <= 3'b111;
        end else begin
            vblk_prev <= VBLK;
            if (param0_wr)
                coins_per_credit <= (DI[3:0] == 4'd0) ? 4'd1 : DI[3:0];
            if (param1_wr)
                credits_per_coin <= DI[3:0];
            if (vblk_rise) begin
                sw_prev <= {INP0[3], INP0[2], INP0[0]};
                if (credit_mode) begin
                    coin_acc <= acc_next;
                    credits  <= bin_to_bcd(cred_bin);
                end
            end
        end
    end

    assign credit_byte = credits;
`endif

    // Read mux; write-mode and unmapped bytes float high.
    always_comb begin
        DO = 8'hFF;
        if (AD[4]) begin
            DO = ctrl;
        end else if (ctrl[4]) begin
            if (ctrl[0]) begin
                case (AD[3:0])
                    4'd0:    DO = credit_mode ? credit_byte : INP0;
                    4'd1:    DO = INP1;
                    default: DO = 8'hFF;
                endcase
            end else if (ctrl[1]) begin
                case (AD[3:0])
                    4'd0:    DO = DSW0;
                    4'd1:    DO = DSW1;
                    default: DO = 8'hFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digdug_cusio06.sv
module tb_digdug_cusio06;

    logic       RESET;
    logic       clkdiv = 1'b0;
    logic       VBLK;
    logic [7:0] INP0, INP1, DSW0, DSW1, DI, DO;
    logic       CS, WR, RD;
    logic [4:0] AD;
    logic       NMI;

    always #5 clkdiv = ~clkdiv;

    digdug_cusio06 #(.NMI_UNIT(64), .CREDIT_MAX(99)) dut (
        .RESET(RESET), .clkdiv(clkdiv), .VBLK(VBLK),
        .INP0(INP0), .INP1(INP1), .DSW0(DSW0), .DSW1(DSW1),
        .CS(CS), .WR(WR), .RD(RD), .AD(AD), .DI(DI),
        .DO(DO), .NMI(NMI)
    );

    typedef struct {
        string      nm;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0] ctrl;
        logic [4:0] ad;
        logic [7:0] inp0, inp1, dsw0, dsw1, exp;
    } vec_t;
    vec_t vecs[12];

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [7:0] cred(input logic [7:0] v);
`ifdef DIGDUG_FREEPLAY_EN
        return 8'h99;
`else
        return v;
`endif
    endfunction

    task automatic sb_push(input string nm, input logic [7:0] exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [7:0] act);
        sb_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty actual=%h", act);
            return;
        end
        e = sb_q.pop_front();
        if (act === e.exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", e.nm, act, e.exp);
    endtask

    task automatic check_nmi(input string nm, input logic exp);
        sb_push(nm, {7'd0, exp});
        #1;
        sb_check({7'd0, NMI});
    endtask

    task automatic peek(input string nm, input logic [4:0] a, input logic [7:0] exp);
        AD = a;
        sb_push(nm, exp);
        #1;
        sb_check(DO);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
        AD = a; CS = 1'b1; RD = 1'b1;
        sb_push(nm, exp);
        #1;
        sb_check(DO);
        @(negedge clkdiv);
        CS = 1'b0; RD = 1'b0;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [7:0] d);
        AD = a; DI = d; CS = 1'b1; WR = 1'b1;
        @(negedge clkdiv);
        CS = 1'b0; WR = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clkdiv);
    endtask

    task automatic vblk_pulse(input logic [7:0] v);
        INP0 = v;
        @(negedge clkdiv);
        VBLK = 1'b1;
        @(negedge clkdiv);
        VBLK = 1'b0;
        @(negedge clkdiv);
    endtask

    task automatic coin();
        vblk_pulse(8'hFE);
        vblk_pulse(8'hFF);
    endtask

    task automatic start(input logic [7:0] mask);
        vblk_pulse(8'hFF & ~mask);
        vblk_pulse(8'hFF);
    endtask

    task automatic set_coinage(input logic [7:0] cpc, input logic [7:0] cpcoin);
        bus_wr(5'h10, 8'h21);
        bus_wr(5'h00, 8'h01);
        bus_wr(5'h00, cpc);
        bus_wr(5'h00, cpcoin);
        bus_wr(5'h00, 8'h00);
        bus_wr(5'h00, 8'h00);
        bus_wr(5'h10, 8'h31);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //               ctrl   ad     inp0   inp1   dsw0   dsw1   exp
        vecs[0]  = '{8'h10, 5'h10, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h10};
        vecs[1]  = '{8'h10, 5'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[2]  = '{8'h32, 5'h00, 8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'hA5};
        vecs[3]  = '{8'h32, 5'h01, 8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'h3C};
        vecs[4]  = '{8'h32, 5'h05, 8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'hFF};
        vecs[5]  = '{8'h31, 5'h00, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h5A};
        vecs[6]  = '{8'h31, 5'h01, 8'hFF, 8'hC3, 8'h00, 8'h00, 8'hC3};
        vecs[7]  = '{8'h31, 5'h02, 8'hFF, 8'hC3, 8'h00, 8'h00, 8'hFF};
        vecs[8]  = '{8'h33, 5'h00, 8'hE7, 8'hFF, 8'h11, 8'h22, 8'hE7};
        vecs[9]  = '{8'h22, 5'h00, 8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'hFF};
        vecs[10] = '{8'h33, 5'h10, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h33};
        vecs[11] = '{8'h30, 5'h00, 8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'hFF};

        RESET = 1'b1; VBLK = 1'b0; CS = 1'b0; WR = 1'b0; RD = 1'b0;
        AD = 5'h00; DI = 8'h00; INP0 = 8'hFF; INP1 = 8'hFF;
        DSW0 = 8'h00; DSW1 = 8'h00;
        idle(3);
        RESET = 1'b0;
        idle(1);

        // Reset state
        check_nmi("rst_nmi", 1'b0);
        peek("rst_ctrl", 5'h10, 8'h10);
        peek("rst_data", 5'h00, 8'hFF);
        idle(1);

        // Read decode table
        for (int i = 0; i < 12; i++) begin
            bus_wr(5'h10, vecs[i].ctrl);
            INP0 = vecs[i].inp0; INP1 = vecs[i].inp1;
            DSW0 = vecs[i].dsw0; DSW1 = vecs[i].dsw1;
            rd_chk($sformatf("vec%0d", i), vecs[i].ad, vecs[i].exp);
        end
        INP0 = 8'hFF; INP1 = 8'hFF;

        // NMI period, acknowledge and stop
        bus_wr(5'h10, 8'h21);
        idle(63);
        check_nmi("nmi_before_64", 1'b0);
        idle(1);
        check_nmi("nmi_at_64", 1'b1);
        rd_chk("nmi_ack_read", 5'h00, 8'hFF);
        check_nmi("nmi_cleared", 1'b0);
        idle(62);
        check_nmi("nmi_before_128", 1'b0);
        idle(1);
        check_nmi("nmi_at_128", 1'b1);
        bus_wr(5'h10, 8'h10);
        check_nmi("nmi_stop_write", 1'b0);
        idle(200);
        check_nmi("nmi_stopped", 1'b0);

        // Coinage 2 coins / 1 credit, credit mode
        bus_wr(5'h10, 8'h21);
        bus_wr(5'h00, 8'h01);
        bus_wr(5'h00, 8'h02);
        bus_wr(5'h00, 8'h01);
        bus_wr(5'h00, 8'h00);
        bus_wr(5'h00, 8'h00);
        bus_wr(5'h00, 8'h02);
        bus_wr(5'h10, 8'h31);
        rd_chk("cred_init", 5'h00, cred(8'h00));
        coin(); coin();
        rd_chk("two_coins", 5'h00, cred(8'h01));
        coin();
        rd_chk("third_coin", 5'h00, cred(8'h01));

        // Coinage 1/1: pending coin_acc completes on the next coin
        set_coinage(8'h01, 8'h01);
        coin();
        rd_chk("coinage_1_1", 5'h00, cred(8'h02));
        for (int i = 0; i < 97; i++) coin();
        rd_chk("cred_99", 5'h00, cred(8'h99));
        coin();
        rd_chk("cred_saturate", 5'h00, cred(8'h99));
        start(8'h08);
        rd_chk("start2", 5'h00, cred(8'h97));
        start(8'h04);
        rd_chk("start1", 5'h00, cred(8'h96));
        start(8'h0C);
        rd_chk("both_starts", 5'h00, cred(8'h94));

        // Control write abandons a parameter sequence
        bus_wr(5'h10, 8'h21);
        bus_wr(5'h00, 8'h01);
        bus_wr(5'h10, 8'h21);
        bus_wr(5'h00, 8'h05);
        bus_wr(5'h10, 8'h31);
        coin();
        rd_chk("param_abort", 5'h00, cred(8'h95));

        // Switch mode returns raw INP0
        bus_wr(5'h10, 8'h21);
        bus_wr(5'h00, 8'h03);
        bus_wr(5'h10, 8'h31);
        INP0 = 8'hA7;
        rd_chk("switch_mode", 5'h00, 8'hA7);
        INP0 = 8'hFF;

        // Reset mid-operation
        bus_wr(5'h10, 8'h21);
        idle(70);
        check_nmi("pre_reset_nmi", 1'b1);
        RESET = 1'b1;
        check_nmi("async_reset_nmi", 1'b0);
        peek("async_reset_ctrl", 5'h10, 8'h10);
        idle(1);
        RESET = 1'b0;
        idle(1);

        // Low-credit corners after reset (coinage back to 1/1)
        bus_wr(5'h10, 8'h21);
        bus_wr(5'h00, 8'h02);
        bus_wr(5'h10, 8'h31);
        rd_chk("rst_credits", 5'h00, cred(8'h00));
        vblk_pulse(8'hFA);
        vblk_pulse(8'hFF);
        rd_chk("coin_then_start", 5'h00, cred(8'h00));
        coin();
        rd_chk("one_credit", 5'h00, cred(8'h01));
        start(8'h08);
        rd_chk("start2_short", 5'h00, cred(8'h01));
        start(8'h04);
        rd_chk("start1_last", 5'h00, cred(8'h00));
        start(8'h04);
        rd_chk("start1_empty", 5'h00, cred(8'h00));
        set_coinage(8'h00, 8'h02);
        coin();
        rd_chk("cpc_zero_as_one", 5'h00, cred(8'h02));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
